// File: rtl/banco_registradores_pkg.sv
// Shared sizing defaults for the MIPS-style register file.
package banco_registradores_pkg;

  localparam int unsigned BANCO_DATA_WIDTH = 32;
  localparam int unsigned BANCO_ADDR_WIDTH = 5;

endpackage

// File: rtl/banco_registradores_cell.sv
// One register of the file: DATA_WIDTH flop with asynchronous clear and write enable.
module banco_reg_cell
  import banco_registradores_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BANCO_DATA_WIDTH
) (
  input  logic                  ck,
  input  logic                  reset_banco,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Asynchronous clear has priority over a coincident enabled write.
  always_ff @(posedge ck or posedge reset_banco) begin
    if (reset_banco) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/banco_registradores.sv
// 2**ADDR_WIDTH-entry register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero.
module banco_registradores
  import banco_registradores_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BANCO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = BANCO_ADDR_WIDTH
) (
  input  logic                  ck,
  input  logic                  reset_banco,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  WE3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:1]      wr_en;

  // Write decoder: one-hot of A3 gated by WE3; entry 0 has no storage so no enable.
  always_comb begin
    wr_en = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      wr_en[i] = WE3 && (A3 == ADDR_WIDTH'(i));
    end
  end

  assign regs[0] = '0;

  for (genvar g = 1; g < int'(NREGS); g++) begin : g_cell
    banco_reg_cell #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cell (
      .ck          (ck),
      .reset_banco (reset_banco),
      .en          (wr_en[g]),
      .d           (WD3),
      .q           (regs[g])
    );
  end

  // Read muxes; entry 0 is the constant zero, so no special case is needed here.
  always_comb begin
    RD1 = regs[A1];
    RD2 = regs[A2];
  end

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores: directed table, corner sequences, random vs model.
module tb_banco_registradores;

  logic        ck;
  logic        reset_banco;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [31:0] RD1, RD2;

  int n_checks = 0;
  int n_err    = 0;

  // Reference contents: what a program would see in each architectural register.
  logic [31:0] mdl [32];

  banco_registradores dut (
    .ck          (ck),
    .reset_banco (reset_banco),
    .A1          (A1),
    .A2          (A2),
    .A3          (A3),
    .WD3         (WD3),
    .WE3         (WE3),
    .RD1         (RD1),
    .RD2         (RD2)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  // Architectural write rule: enabled, not in reset, and never to register 0.
  task automatic model_write(input logic we, input logic [4:0] a, input logic [31:0] d);
    if (we && a != 5'd0 && !reset_banco) mdl[a] = d;
  endtask

  // Drive at the falling edge, commit at the rising edge, return 1 time unit later.
  task automatic step(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2);
    @(negedge ck);
    WE3 = we; A3 = a3; WD3 = wd; A1 = a1; A2 = a2;
    @(posedge ck);
    model_write(we, a3, wd);
    #1;
  endtask

  initial begin
    logic [4:0]  ra1, ra2, ra3;
    logic [31:0] rwd;
    logic        rwe;

    reset_banco = 1'b1;
    WE3 = 1'b0; A1 = 5'd0; A2 = 5'd0; A3 = 5'd0; WD3 = 32'h0;
    model_clear();
    #2;
    A1 = 5'd7; A2 = 5'd31;
    #1;
    chk("reset_rd1", RD1, 32'h0);
    chk("reset_rd2", RD2, 32'h0);
    @(negedge ck);
    #2 reset_banco = 1'b0;

    // Directed table: each row is one write cycle followed by reads after the edge.
    vecs[0] = '{"wr8_read_both", 1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd8, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{"wr0_discarded", 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{"we0_no_change", 1'b0, 5'd9,  32'h12345678, 5'd8,  5'd9, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{"wr10",          1'b1, 5'd10, 32'hA5A5A5A5, 5'd10, 5'd9, 32'hA5A5A5A5, 32'h0};
    vecs[4] = '{"wr31",          1'b1, 5'd31, 32'h0BADF00D, 5'd31, 5'd0, 32'h0BADF00D, 32'h0};
    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].a3, vecs[i].wd, vecs[i].a1, vecs[i].a2);
      chk({vecs[i].name, "_rd1"}, RD1, vecs[i].e1);
      chk({vecs[i].name, "_rd2"}, RD2, vecs[i].e2);
    end

    // Read-during-write: old value visible until the edge, new value after.
    @(negedge ck);
    WE3 = 1'b1; A3 = 5'd10; WD3 = 32'h5A5A5A5A; A1 = 5'd10; A2 = 5'd10;
    #1;
    chk("rdw_before_rd1", RD1, 32'hA5A5A5A5);
    chk("rdw_before_rd2", RD2, 32'hA5A5A5A5);
    @(posedge ck);
    model_write(1'b1, 5'd10, 32'h5A5A5A5A);
    #1;
    chk("rdw_after_rd1", RD1, 32'h5A5A5A5A);

    // Fill every register with index * 0x01010101, then sweep both ports.
    for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
    @(negedge ck);
    WE3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #1;
      chk($sformatf("sweep_rd1_%0d", i), RD1, 32'(i) * 32'h01010101);
      chk($sformatf("sweep_rd2_%0d", 31 - i), RD2, 32'(31 - i) * 32'h01010101);
    end

    // Reset mid-cycle with populated registers clears reads immediately; writes ignored.
    @(negedge ck);
    A1 = 5'd5; A2 = 5'd31; WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hCAFEF00D;
    #2 reset_banco = 1'b1;
    model_clear();
    #1;
    chk("async_reset_rd1", RD1, 32'h0);
    chk("async_reset_rd2", RD2, 32'h0);
    @(posedge ck);
    #1;
    chk("write_in_reset_ignored", RD1, 32'h0);
    // Deassert mid-cycle; first write lands at the following edge.
    #2 reset_banco = 1'b0;
    #1;
    chk("post_reset_before_edge", RD1, 32'h0);
    @(posedge ck);
    model_write(1'b1, 5'd5, 32'hCAFEF00D);
    #1;
    chk("post_reset_first_write", RD1, 32'hCAFEF00D);

    // Reset raised in the same timestep as an enabled write edge: reset wins.
    @(negedge ck);
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h33333333; A1 = 5'd3; A2 = 5'd5;
    @(posedge ck);
    reset_banco = 1'b1;
    model_clear();
    #1;
    chk("reset_at_edge_rd1", RD1, 32'h0);
    chk("reset_at_edge_rd2", RD2, 32'h0);
    @(negedge ck);
    WE3 = 1'b0;
    reset_banco = 1'b0;

    // Random traffic against the model, checking reads both before and after each edge.
    for (int n = 0; n < 400; n++) begin
      rwe = 1'($urandom_range(0, 1));
      ra3 = 5'($urandom_range(0, 31));
      rwd = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? ra3 : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 7) == 0) ? ra1 : 5'($urandom_range(0, 31));
      @(negedge ck);
      WE3 = rwe; A3 = ra3; WD3 = rwd; A1 = ra1; A2 = ra2;
      #1;
      chk("rand_pre_rd1", RD1, mdl[ra1]);
      chk("rand_pre_rd2", RD2, mdl[ra2]);
      @(posedge ck);
      model_write(rwe, ra3, rwd);
      #1;
      chk("rand_post_rd1", RD1, mdl[ra1]);
      chk("rand_post_rd2", RD2, mdl[ra2]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
